// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply / divide unit feeding the writeback
// mux input 3. One iteration per clock; WIDTH iterations per operation, except
// divide by zero, which completes straight from IDLE.
//
// Ports:
//   clk     - system clock, all state changes on the rising edge
//   rst_n   - asynchronous active-low reset
//   start   - level request from the decoder, held while the instruction is current
//   op      - 00 MUL low, 01 MUL high, 10 DIVU quotient, 11 REMU remainder
//   a, b    - operands (multiplicand/dividend, multiplier/divisor)
//   busy    - registered, high in RUN
//   done    - registered, one-cycle pulse in DONE; result valid this cycle
//   stall   - combinational, high from the first IDLE cycle with start through
//             the last RUN cycle
//   result  - registered result, held until the next DONE
//
// Handshake: start is a level request. It is sampled only in IDLE; the
// operands and op are captured on that edge. done answers it exactly once.
// Any start seen in RUN or DONE belongs to the instruction already accepted.
// The first IDLE cycle after DONE accepts a new start.
module muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   acc, acc_next;    // product, or {remainder, quotient}
  logic [2*WIDTH-1:0]   opnd, opnd_next;  // shifted multiplicand / dividend
  logic [WIDTH-1:0]     b_q, b_next;      // multiplier (shifted) / divisor
  logic [1:0]           op_q, op_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [WIDTH-1:0]     result_next;

  // One iteration of the datapath, evaluated from the current registers.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_diff;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   acc_step;

  always_comb begin
    // Restoring division: bring the next dividend bit (MSB first) into the
    // partial remainder, then subtract the divisor if it fits.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], opnd[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    q_bit    = (rem_sh >= {1'b0, b_q});
    if (op_q[1]) begin
      acc_step = {(q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                  acc[WIDTH-2:0], q_bit};
    end else begin
      // Shift-add multiply, LSB of the multiplier first.
      acc_step = acc + (b_q[0] ? opnd : {(2*WIDTH){1'b0}});
    end
  end

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    opnd_next   = opnd;
    b_next      = b_q;
    op_next     = op_q;
    cnt_next    = cnt;
    result_next = result;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          acc_next  = '0;
          cnt_next  = '0;
          opnd_next = {{WIDTH{1'b0}}, a};
          b_next    = b;
          op_next   = op;
          if (op[1] && (b == '0)) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            state_next  = DONE;
            result_next = op[0] ? a : {WIDTH{1'b1}};
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        stall     = 1'b1;
        acc_next  = acc_step;
        opnd_next = opnd << 1;
        if (!op_q[1]) begin
          b_next = b_q >> 1;
        end
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
          // Both product and {remainder, quotient} keep the op[0]=1 answer in
          // the upper half, so op[0] alone picks the half.
          result_next = op_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      opnd   <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      opnd   <= opnd_next;
      b_q    <= b_next;
      op_q   <= op_next;
      cnt    <= cnt_next;
      result <= result_next;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, stall;
  logic [W-1:0] result;

  muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .result (result)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           total    = 0;
  int           bad      = 0;
  logic [W-1:0] last_res = '0;

  // reference model: plain arithmetic
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [1:0] o);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (y == '0) ? {W{1'b1}} : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge. Drives one instruction, checks
  // {busy,done,stall} every cycle, latency and result. Returns just after the
  // edge that ends DONE. hold keeps start high through DONE; scramble changes
  // the operand inputs while the operation runs.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [1:0] top, input bit hold, input bit scramble,
                       input string tag);
    logic [W-1:0] exp;
    logic [2:0]   exp_flags;
    int           lat;
    int           cyc;
    bit           seen;
    exp   = model(ta, tb_v, top);
    lat   = (top[1] && tb_v == '0) ? 1 : W + 1;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    op    = top;
    cyc   = 0;
    seen  = 0;
    while (!seen && cyc <= W + 4) begin
      @(negedge clk);
      exp_flags = {(cyc >= 1 && cyc < lat), (cyc == lat), (cyc < lat)};
      check({tag, " busy/done/stall"}, 32'({busy, done, stall}), 32'(exp_flags));
      if (done) begin
        seen = 1;
      end else begin
        step();
        cyc++;
        if (!hold) start = 1'b0;
        if (scramble) begin
          a  = W'($urandom);
          b  = W'($urandom);
          op = 2'($urandom);
        end
      end
    end
    check({tag, " latency"}, 32'(seen ? cyc : -1), 32'(lat));
    check({tag, " result"}, 32'(result), 32'(exp));
    last_res = exp;
    if (!hold) start = 1'b0;
    step();
  endtask

  task automatic idle_check(input int n, input string tag);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " idle flags"}, 32'({busy, done, stall}), 32'(0));
      check({tag, " held result"}, 32'(result), 32'(last_res));
      step();
    end
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check("reset flags", 32'({busy, done, stall}), 32'(0));
    check("reset result", 32'(result), 32'(0));
    step();
    rst_n = 1'b1;
    step();

    // MUL low / high
    do_op(16'h1234, 16'h0100, 2'b00, 0, 0, "mul_lo");
    idle_check(3, "mul_lo");
    do_op(16'h1234, 16'h0100, 2'b01, 0, 0, "mul_hi");
    idle_check(2, "mul_hi");

    // Reset mid-RUN: result cleared, no done afterwards
    start = 1'b1; a = 16'd5; b = 16'd7; op = 2'b00;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("rst_run flags", 32'({busy, done}), 32'(0));
    check("rst_run result", 32'(result), 32'(0));
    step();
    rst_n = 1'b1;
    last_res = '0;
    idle_check(W + 4, "rst_run");

    // MUL max
    do_op(16'hFFFF, 16'hFFFF, 2'b00, 0, 0, "mulmax_lo");
    do_op(16'hFFFF, 16'hFFFF, 2'b01, 0, 0, "mulmax_hi");

    // DIVU / REMU
    do_op(16'd1000, 16'd7, 2'b10, 0, 0, "divu");
    do_op(16'd1000, 16'd7, 2'b11, 0, 0, "remu");
    do_op(16'd5, 16'd9, 2'b10, 0, 0, "divu_small");
    do_op(16'd5, 16'd9, 2'b11, 0, 0, "remu_small");

    // divide by zero
    do_op(16'h00AB, 16'h0000, 2'b10, 0, 0, "div0_q");
    idle_check(2, "div0_q");
    do_op(16'h00AB, 16'h0000, 2'b11, 0, 0, "div0_r");
    idle_check(2, "div0_r");

    // start held through DONE, inputs changed in RUN, back-to-back restart
    do_op(16'hBEEF, 16'h0013, 2'b10, 1, 1, "b2b_first");
    do_op(16'h0F0F, 16'h00F1, 2'b00, 0, 0, "b2b_second");
    idle_check(3, "b2b");

    // randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   ro;
      bit           rh, rs;
      ra = W'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        default: rb = W'($urandom);
      endcase
      ro = 2'($urandom_range(0, 3));
      rh = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, ro, rh, rs, "rand");
      if (!rh && $urandom_range(0, 2) == 0) idle_check(1, "rand");
    end
    idle_check(2, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative 16-bit multiply/divide unit that sits directly upstream of the writeback-select 4:1 mux and drives that mux's fourth data input (sel = 2'b11).
- Takes operands from the register-file read ports and an op code from the decoder.
- Computes the result over WIDTH cycles.
- Raises stall to freeze the PC and register-file write until the result is valid.

Parameters:
WIDTH, 16, operand and result width in bits (>= 4).
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  decoder asserts for a mul/div instruction; level signal held while the instruction is current.
op  input  2  00 = MUL low half, 01 = MUL high half (unsigned), 10 = DIVU quotient, 11 = REMU remainder.
a  input  WIDTH  operand A (multiplicand / dividend).
b  input  WIDTH  operand B (multiplier / divisor).
busy  output  1  high while an operation is in progress (state RUN).
done  output  1  one-cycle pulse; result is valid and writeback is enabled this cycle.
stall  output  1  combinational: (state==RUN) | (state==IDLE & start); freezes PC and blocks the regfile write.
result  output  WIDTH  selected result, fed to the writeback mux in4.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal accumulator, operand registers and counter cleared.
  - Reset asserted mid-operation aborts the operation immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1, latch a, b and op.
  - Clear the 2*WIDTH accumulator; counter=0.
  - If op[1]=1 and b==0, go directly to DONE; otherwise go to RUN.
  - start=0 stays in IDLE.
- RUN (busy=1):
  - One iteration per cycle; counter increments.
  - After WIDTH iterations (counter==WIDTH-1 on the edge), go to DONE.
  - start, a, b and op are ignored in RUN; operands are already latched.
- MUL: shift-add, LSB first, unsigned.
  - Full 2*WIDTH product.
  - op 00 returns product[WIDTH-1:0]; op 01 returns product[2*WIDTH-1:WIDTH].
- DIVU/REMU: restoring division, MSB first, unsigned.
  - Quotient and remainder each WIDTH bits.
- Divide by zero:
  - quotient = all ones; remainder = a.
  - Latency 1 cycle (IDLE -> DONE); no exception raised.
- DONE:
  - done=1 for exactly one cycle; result registered and valid.
  - Next state is IDLE unconditionally.
  - start being high in DONE is ignored; it belongs to the completing instruction.
- Latency (start sampled at edge E0):
  - Normal operation: done high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles.
  - Divide by zero: done high in the cycle after E0.
- stall timing:
  - High from the first cycle start is seen in IDLE through the last RUN cycle.
  - Low in DONE, so the PC advances on the edge ending DONE.
- Back-to-back: a new start in the cycle after DONE (state IDLE) is accepted normally.
- result holds its value after DONE until the next DONE; it is not cleared in IDLE.
- busy and done are registered outputs, derived from state; they are never both high.

Test Plan:
1. Reset mid-RUN:
   - Start MUL a=5, b=7; assert rst_n=0 at cycle 4.
   - Required: busy=0, done=0, result=0 immediately.
   - After release with start=0: stays IDLE, no done pulse.
2. MUL low/high:
   - a=16'h1234, b=16'h0100, op=00 -> done at cycle 17, result=16'h3400.
   - Same operands, op=01 -> result=16'h0012.
   - stall high for cycles 0-16, low at 17.
3. MUL max:
   - a=b=16'hFFFF, op=00 -> result=16'h0001.
   - Same operands, op=01 -> result=16'hFFFE.
4. DIVU/REMU:
   - a=1000, b=7: op=10 -> result=142; op=11 -> result=6.
   - a=5, b=9: op=10 -> 0; op=11 -> 5.
5. Divide by zero:
   - a=16'h00AB, b=0, op=10 -> done on the cycle after start, result=16'hFFFF, busy never high.
   - Same with op=11 -> result=16'h00AB.
6. Back-to-back and ignored inputs:
   - Hold start high through DONE; change a, b and op during RUN.
   - Required: exactly one done pulse; result uses the latched operands.
   - A second start in the cycle after DONE is accepted, and its done arrives WIDTH+1 cycles later.
